// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : fetch FSM states (RUN / SQUASH), 1-bit encoding
//   PC_STEP          : sequential PC increment (one 32-bit word)
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_SQUASH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry {data, pc} skid buffer for the fetch stage.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   load_i          : capture data_i/pc_i and set valid
//   drain_i         : entry consumed, clear valid
//   flush_i         : discard entry (highest priority)
//   data_i, pc_i    : entry to capture
//   valid_o, data_o, pc_o : buffered entry
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        flush_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] data_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads on the
// instruction bus and hands registered {inst_code, pc_addr} to ID.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   stall                   : ID cannot accept, output register holds
//   redirect, redirect_pc   : replace PC and flush undelivered fetches
//   ibus_req, ibus_addr     : bus read request and word address
//   ibus_ack, ibus_rdata    : bus completion and read data
//   inst_code, pc_addr      : instruction word and its address to ID
//   inst_valid              : inst_code/pc_addr valid
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] inst_code,
  output logic [31:0] pc_addr,
  output logic        inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_code_q, out_code_d;
  logic [31:0]  out_pc_q, out_pc_d;

  logic         skid_load, skid_drain, skid_flush;
  logic         skid_valid;
  logic [31:0]  skid_data, skid_pc;
  logic         xfer;
  logic [31:0]  redirect_target;

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (skid_flush),
    .data_i  (ibus_rdata),
    .pc_i    (pc_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

  // The skid only fills on an ack edge, so dropping req on skid_valid
  // never cuts a transfer short.
  assign ibus_req = (state_q == FETCH_RUN || state_q == FETCH_SQUASH)
                    && !skid_valid && rst_n;
  assign xfer            = ibus_req && ibus_ack;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_pc_d    = out_pc_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_flush  = 1'b0;

    if (redirect) begin
      out_valid_d = 1'b0;
      skid_flush  = 1'b1;
      pc_d        = redirect_target;
      // An unacked request must finish at its old address; its data
      // belongs to the flushed path and is dropped in SQUASH.
      if (ibus_req && !ibus_ack) begin
        state_d = FETCH_SQUASH;
      end else begin
        state_d = FETCH_RUN;
        addr_d  = redirect_target;
      end
    end else if (state_q == FETCH_SQUASH) begin
      if (xfer) begin
        state_d = FETCH_RUN;
        addr_d  = pc_q;
      end
      if (out_valid_q && !stall) out_valid_d = 1'b0;
    end else if (xfer) begin
      pc_d   = pc_q + PC_STEP;
      addr_d = pc_q + PC_STEP;
      if (!out_valid_q || !stall) begin
        out_valid_d = 1'b1;
        out_code_d  = ibus_rdata;
        out_pc_d    = pc_q;
      end else begin
        skid_load = 1'b1;
      end
    end else if (skid_valid && !stall) begin
      skid_drain  = 1'b1;
      out_valid_d = 1'b1;
      out_code_d  = skid_data;
      out_pc_d    = skid_pc;
    end else if (!stall) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH_RUN;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign ibus_addr  = addr_q;
  assign inst_code  = out_code_q;
  assign pc_addr    = out_pc_q;
  assign inst_valid = out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] inst_code;
  logic [31:0] pc_addr;
  logic        inst_valid;

  logic        zw;
  logic        ack_m;
  logic [31:0] rdata_m;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  // Zero-wait slave (ack=req, rdata=addr^FFFF0000) or manually driven ack.
  assign ibus_ack   = zw ? ibus_req : ack_m;
  assign ibus_rdata = zw ? (ibus_addr ^ 32'hFFFF_0000) : rdata_m;

  if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ibus_req    (ibus_req),
    .ibus_addr   (ibus_addr),
    .ibus_ack    (ibus_ack),
    .ibus_rdata  (ibus_rdata),
    .inst_code   (inst_code),
    .pc_addr     (pc_addr),
    .inst_valid  (inst_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    zw = 1'b1; ack_m = 1'b0; rdata_m = '0;

    // Reset
    #1;
    chk("rst_req_low", {31'd0, ibus_req}, 32'd0);
    step(); step();
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc_addr", pc_addr, 32'd0);
    chk("rst_code", inst_code, 32'd0);
    chk("rst_addr", ibus_addr, 32'hBFC0_0000);

    // Zero-wait streaming
    rst_n = 1'b1;
    #1;
    chk("zw_req0", {31'd0, ibus_req}, 32'd1);
    chk("zw_addr0", ibus_addr, 32'hBFC0_0000);
    chk("zw_valid0", {31'd0, inst_valid}, 32'd0);
    step();
    chk("zw_addr1", ibus_addr, 32'hBFC0_0004);
    chk("zw_valid1", {31'd0, inst_valid}, 32'd1);
    chk("zw_pc1", pc_addr, 32'hBFC0_0000);
    chk("zw_code1", inst_code, 32'h403F_0000);
    step();
    chk("zw_addr2", ibus_addr, 32'hBFC0_0008);
    chk("zw_pc2", pc_addr, 32'hBFC0_0004);
    chk("zw_code2", inst_code, 32'h403F_0004);

    // Restart under manual slave for stall/skid
    zw = 1'b0; ack_m = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; ack_m = 1'b1; rdata_m = 32'h3C08_BFC0;
    step();
    chk("st_pc0", pc_addr, 32'hBFC0_0000);
    chk("st_addr0", ibus_addr, 32'hBFC0_0004);
    stall = 1'b1; ack_m = 1'b1; rdata_m = 32'h2408_0001;
    step();
    ack_m = 1'b0; rdata_m = 32'h0;
    #1;
    chk("st_req_skid", {31'd0, ibus_req}, 32'd0);
    chk("st_hold_code", inst_code, 32'h3C08_BFC0);
    chk("st_hold_pc", pc_addr, 32'hBFC0_0000);
    step();
    chk("st_hold_code2", inst_code, 32'h3C08_BFC0);
    chk("st_req_skid2", {31'd0, ibus_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("dr_code", inst_code, 32'h2408_0001);
    chk("dr_pc", pc_addr, 32'hBFC0_0004);
    chk("dr_valid", {31'd0, inst_valid}, 32'd1);
    chk("dr_req", {31'd0, ibus_req}, 32'd1);
    chk("dr_addr", ibus_addr, 32'hBFC0_0008);

    // Redirect in 2nd cycle of a 3-cycle read at BFC00008
    step();
    chk("sq_c1_valid", {31'd0, inst_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h8000_0103;
    step();
    redirect = 1'b0;
    #1;
    chk("sq_c2_req", {31'd0, ibus_req}, 32'd1);
    chk("sq_c2_addr", ibus_addr, 32'hBFC0_0008);
    ack_m = 1'b1; rdata_m = 32'hDEAD_BEEF;
    step();
    ack_m = 1'b0;
    #1;
    chk("sq_valid", {31'd0, inst_valid}, 32'd0);
    chk("sq_newaddr", ibus_addr, 32'h8000_0100);
    chk("sq_req", {31'd0, ibus_req}, 32'd1);

    // Redirect on the same edge as an ack
    ack_m = 1'b1; rdata_m = 32'h1111_1111;
    redirect = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect = 1'b0; ack_m = 1'b0;
    #1;
    chk("ra_valid", {31'd0, inst_valid}, 32'd0);
    chk("ra_addr", ibus_addr, 32'h8000_0200);

    // Redirect while stalled with skid full
    ack_m = 1'b1; rdata_m = 32'hAAAA_0001;
    step();
    chk("rs_code", inst_code, 32'hAAAA_0001);
    chk("rs_pc", pc_addr, 32'h8000_0200);
    stall = 1'b1; rdata_m = 32'hAAAA_0002;
    step();
    ack_m = 1'b0;
    #1;
    chk("rs_skid_req", {31'd0, ibus_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    redirect = 1'b0;
    #1;
    chk("rs_valid", {31'd0, inst_valid}, 32'd0);
    chk("rs_req", {31'd0, ibus_req}, 32'd1);
    chk("rs_addr", ibus_addr, 32'h8000_0300);

    // One-cycle reset while waiting on a read
    stall = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_req_low", {31'd0, ibus_req}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_valid", {31'd0, inst_valid}, 32'd0);
    chk("mr_pc_addr", pc_addr, 32'd0);
    chk("mr_req", {31'd0, ibus_req}, 32'd1);
    chk("mr_addr", ibus_addr, 32'hBFC0_0000);
    ack_m = 1'b1; rdata_m = 32'h1234_5678;
    step();
    ack_m = 1'b0;
    #1;
    chk("mr_code", inst_code, 32'h1234_5678);
    chk("mr_pc", pc_addr, 32'hBFC0_0000);
    chk("mr_next_addr", ibus_addr, 32'hBFC0_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage: owns the PC and issues word reads on the instruction bus.
- Delivers registered inst_code/pc_addr with a valid flag to the ID stage.
- Sits between instruction memory/bus and ID; absorbs downstream stall with a one-entry skid buffer.
- Handles redirects (branch/jump/exception), including squashing an in-flight read.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- stall  input  1  ID cannot accept; output register must hold
- redirect  input  1  replace PC and flush fetched-but-undelivered instructions
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 00)
- ibus_req  output  1  read request to instruction bus
- ibus_addr  output  32  word-aligned read address, registered
- ibus_ack  input  1  read complete this cycle; may assert in the first req cycle
- ibus_rdata  input  32  read data, valid only when ibus_ack=1
- inst_code  output  32  instruction word to ID
- pc_addr  output  32  address of inst_code
- inst_valid  output  1  inst_code/pc_addr valid

Behaviour:
- One clock; reset is synchronous and active-low, on rst_n sampled at the rising edge of clk.
- Reset values:
  - pc=RESET_PC, ibus_addr=RESET_PC
  - inst_valid=0, inst_code=0, pc_addr=0
  - skid empty, state=RUN
  - ibus_req=0 while rst_n=0
- Bus protocol:
  - A transfer completes on an edge with ibus_req=1 and ibus_ack=1.
  - Once raised, ibus_req and ibus_addr stay stable until ack.
  - Back-to-back transfers are allowed (1/cycle with a zero-wait slave).
- ibus_req = (state in {RUN,SQUASH}) && !skid_valid && rst_n. The skid fills only on an ack edge, so req never drops mid-transfer.
- ID handoff: a transfer to ID occurs on an edge with inst_valid=1 and stall=0.
- Latency: ack at edge N → inst_valid=1 during cycle N+1.
- FSM states:
  - RUN: normal fetch; ibus_addr=pc.
  - SQUASH: an outstanding read belongs to a flushed path. Keep req and old address; on ack discard data, go to RUN, and ibus_addr<=pc (already the redirect target).
- RUN ack, no redirect: pc<=pc+4 (wraps mod 2^32) and ibus_addr<=pc+4. Then exactly one of:
  - if (!inst_valid || !stall): output<={rdata, pc}, inst_valid=1
  - else: skid<={rdata, pc}, skid_valid=1
- Skid drain: when skid_valid && !stall, output<=skid and skid_valid<=0. The request resumes the next cycle.
- Output consumed with no new data: inst_valid<=0.
- Redirect has priority over ack, stall and skid. On a redirect edge:
  - inst_valid<=0, skid_valid<=0
  - pc<={redirect_pc[31:2],2'b00}
  - if req=1 and ack=0: state<=SQUASH, ibus_addr unchanged
  - otherwise (ack this edge, or no request): returned data dropped, state RUN, ibus_addr<=new pc
- Redirect while in SQUASH: pc updated again; remain in SQUASH.
- Reset mid-request: the transfer is abandoned; the bus slave shares rst_n and is reset with it.
- Output register never changes while inst_valid && stall, except on redirect or reset.

Decomposition:
- Shared defs file holds:
  - RESET_PC default vector
  - FETCH_RUN/FETCH_SQUASH state encodings (1 bit)
  - PC_STEP (4)
- Natural sub-module: fetch_skid, a one-entry {data,pc} buffer with load/drain/flush and a valid flag.

Test Plan:
- Reset release, zero-wait slave (ack=req, rdata=addr^32'hFFFF0000):
  - ibus_addr BFC00000, BFC00004, BFC00008 on consecutive cycles
  - inst_valid high from the cycle after the first ack; pc_addr tracks one behind.
- Stall with a pending ack: hold stall=1 while output holds BFC00000, ack data 32'h24080001 for BFC00004.
  - Skid fills and ibus_req=0 next cycle.
  - On stall release, output shows 24080001/BFC00004 the next cycle; req resumes with addr BFC00008 that same cycle.
- Redirect to 32'h80000103 during the 2nd cycle of a 3-cycle-latency read at BFC00008:
  - req/addr stay BFC00008 until ack; data discarded, inst_valid=0.
  - Next req addr is 80000100.
- Redirect to 32'h80000200 on the same edge as an ack: data dropped, inst_valid=0, ibus_addr=80000200 the next cycle.
- Redirect while stall=1 and skid full:
  - inst_valid=0 and skid empty next cycle.
  - ibus_req=1 at the redirect address despite stall.
- rst_n=0 for one cycle mid-wait:
  - next cycle ibus_req=0, inst_valid=0, pc_addr=0
  - after release, first req addr BFC00000.
